count_seq_monitor: RTL and testbench

- Receive-side checker for the free-running up-counter bus that the top-level counter block drives (the 4-bit `counter_up` output).
- Samples the bus every `clk_in` edge and classifies each value change as a legal +1 step, a wrap (max→0) or an illegal jump.
- Measures dwell time per count value, flags stalls, and keeps saturating step/wrap/error statistics for bring-up and board test.
- `count_in` is synchronous to `clk_in`; no synchronizer inside.

---
 rtl/count_seq_monitor.sv | 152 +++++++++++++++
 tb/tb_count_seq_monitor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/count_seq_monitor.sv
// Receive-side checker for a free-running up-counter bus: classifies every value
// change as step, wrap or illegal jump, measures dwell per value and keeps statistics.
module count_seq_monitor #(
    parameter int CNT_W   = 4,
    parameter int PER_W   = 24,
    parameter int TIMEOUT = 1000000
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [CNT_W-1:0] count_in,
    input  logic             clr,
    output logic             locked,
    output logic             fault,
    output logic             stall,
    output logic             step_pulse,
    output logic             wrap_pulse,
    output logic             err_pulse,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic [15:0]      step_count,
    output logic [7:0]       wrap_count,
    output logic [7:0]       err_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACQ   = 2'd1;
    localparam logic [1:0] S_TRACK = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    // dwell equals this value on the edge before the TIMEOUT-th unchanged edge
    localparam logic [PER_W-1:0] STALL_AT = PER_W'(TIMEOUT - 1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [PER_W-1:0] sat_inc_per(input logic [PER_W-1:0] v);
        return (v == '1) ? v : v + PER_W'(1);
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] last_q;
    logic [PER_W-1:0] dwell;
    logic [CNT_W-1:0] next_val;
    logic             changed;
    logic             legal;
    logic             is_wrap;

    assign next_val = last_q + CNT_W'(1);
    assign changed  = (count_in != last_q);
    assign legal    = changed && (count_in == next_val);
    assign is_wrap  = legal && (last_q == CNT_MAX);
    assign locked   = (state == S_TRACK);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            last_q       <= '0;
            dwell        <= '0;
            fault        <= 1'b0;
            stall        <= 1'b0;
            step_pulse   <= 1'b0;
            wrap_pulse   <= 1'b0;
            err_pulse    <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            step_count   <= '0;
            wrap_count   <= '0;
            err_count    <= '0;
        end else begin
            step_pulse   <= 1'b0;
            wrap_pulse   <= 1'b0;
            err_pulse    <= 1'b0;
            period_valid <= 1'b0;

            // clr wins over anything the current edge would otherwise classify
            if (clr) begin
                step_count <= '0;
                wrap_count <= '0;
                err_count  <= '0;
                fault      <= 1'b0;
                stall      <= 1'b0;
                period     <= '0;
                dwell      <= '0;
                last_q     <= count_in;
                state      <= S_ACQ;
            end else begin
                case (state)
                    S_IDLE: begin
                        last_q <= count_in;
                        dwell  <= '0;
                        state  <= S_ACQ;
                    end
                    S_ACQ: begin
                        if (legal) begin
                            step_pulse <= 1'b1;
                            wrap_pulse <= is_wrap;
                            step_count <= sat_inc16(step_count);
                            if (is_wrap) wrap_count <= sat_inc8(wrap_count);
                            last_q     <= count_in;
                            dwell      <= '0;
                            state      <= S_TRACK;
                        end else if (changed) begin
                            err_pulse <= 1'b1;
                            err_count <= sat_inc8(err_count);
                            last_q    <= count_in;
                            dwell     <= '0;
                        end else begin
                            dwell <= sat_inc_per(dwell);
                        end
                    end
                    S_TRACK: begin
                        if (legal) begin
                            step_pulse   <= 1'b1;
                            wrap_pulse   <= is_wrap;
                            step_count   <= sat_inc16(step_count);
                            if (is_wrap) wrap_count <= sat_inc8(wrap_count);
                            period       <= sat_inc_per(dwell);
                            period_valid <= 1'b1;
                            stall        <= 1'b0;
                            last_q       <= count_in;
                            dwell        <= '0;
                        end else if (changed) begin
                            err_pulse <= 1'b1;
                            err_count <= sat_inc8(err_count);
                            fault     <= 1'b1;
                            stall     <= 1'b0;
                            last_q    <= count_in;
                            dwell     <= '0;
                            state     <= S_FAULT;
                        end else begin
                            dwell <= sat_inc_per(dwell);
                            if (dwell == STALL_AT) stall <= 1'b1;
                        end
                    end
                    S_FAULT: begin
                        // follow the bus silently so nothing is flagged until re-acquired
                        last_q <= count_in;
                        dwell  <= '0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed bench for count_seq_monitor with a short stall timeout.
module tb_count_seq_monitor;
    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  count_in = 4'd0;
    logic        clr = 1'b0;
    logic        locked, fault, stall, step_pulse, wrap_pulse, err_pulse;
    logic [23:0] period;
    logic        period_valid;
    logic [15:0] step_count;
    logic [7:0]  wrap_count, err_count;

    int errors = 0;
    int checks = 0;

    count_seq_monitor #(.CNT_W(4), .PER_W(24), .TIMEOUT(16)) dut (
        .clk_in(clk_in), .rst(rst), .count_in(count_in), .clr(clr),
        .locked(locked), .fault(fault), .stall(stall),
        .step_pulse(step_pulse), .wrap_pulse(wrap_pulse), .err_pulse(err_pulse),
        .period(period), .period_valid(period_valid),
        .step_count(step_count), .wrap_count(wrap_count), .err_count(err_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Holds reset for two edges with count_in = v, then releases it just after an edge.
    task automatic do_reset(input logic [3:0] v);
        rst = 1'b1; clr = 1'b0; count_in = v;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(4'd0);
        checks++; if ({locked, fault, stall, step_pulse, wrap_pulse, err_pulse, period_valid} !== 7'b0) begin errors++; $display("FAIL reset_flags got=%b want=0", {locked, fault, stall, step_pulse, wrap_pulse, err_pulse, period_valid}); end
        checks++; if ({period, step_count, wrap_count, err_count} !== '0) begin errors++; $display("FAIL reset_values period=%0d steps=%0d wraps=%0d errs=%0d want all 0", period, step_count, wrap_count, err_count); end
    endtask

    task automatic test_count_seq();
        logic [3:0] v;
        int exp_steps = 0;
        do_reset(4'd0);
        for (int i = 0; i < 20; i++) begin
            v = 4'(i);
            count_in = v;
            if (i > 0) exp_steps++;
            for (int k = 0; k < 4; k++) begin
                tick();
                if (k == 0 && i > 0) begin
                    checks++; if (step_pulse !== 1'b1) begin errors++; $display("FAIL seq_step i=%0d got=%b want=1", i, step_pulse); end
                    checks++; if (wrap_pulse !== (v == 4'd0)) begin errors++; $display("FAIL seq_wrap i=%0d got=%b want=%b", i, wrap_pulse, (v == 4'd0)); end
                    checks++; if (period_valid !== (i > 1)) begin errors++; $display("FAIL seq_pvalid i=%0d got=%b want=%b", i, period_valid, (i > 1)); end
                    if (i > 1) begin
                        checks++; if (period !== 24'd4) begin errors++; $display("FAIL seq_period i=%0d got=%0d want=4", i, period); end
                    end
                    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL seq_locked i=%0d got=%b want=1", i, locked); end
                end else begin
                    checks++; if ({step_pulse, wrap_pulse, err_pulse, period_valid} !== 4'b0) begin errors++; $display("FAIL seq_quiet i=%0d k=%0d got=%b want=0", i, k, {step_pulse, wrap_pulse, err_pulse, period_valid}); end
                end
                if (i == 0) begin
                    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL seq_unlocked k=%0d got=%b want=0", k, locked); end
                end
            end
        end
        checks++; if (step_count !== 16'(exp_steps)) begin errors++; $display("FAIL seq_step_count got=%0d want=%0d", step_count, exp_steps); end
        checks++; if (wrap_count !== 8'd1) begin errors++; $display("FAIL seq_wrap_count got=%0d want=1", wrap_count); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL seq_err_count got=%0d want=0", err_count); end
    endtask

    task automatic test_illegal_jump();
        do_reset(4'd4);
        tick(); tick();
        count_in = 4'd5; tick();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL jump_locked got=%b want=1", locked); end
        count_in = 4'd7; tick();
        checks++; if ({err_pulse, fault, locked} !== 3'b110) begin errors++; $display("FAIL jump_detect err/fault/locked got=%b want=110", {err_pulse, fault, locked}); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL jump_err_count got=%0d want=1", err_count); end
        tick();
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL jump_err_oneshot got=%b want=0", err_pulse); end
        count_in = 4'd8; tick();
        count_in = 4'd9; tick();
        checks++; if ({step_count, step_pulse, fault} !== {16'd1, 1'b0, 1'b1}) begin errors++; $display("FAIL jump_frozen steps=%0d step=%b fault=%b want 1/0/1", step_count, step_pulse, fault); end
        clr = 1'b1; tick(); clr = 1'b0;
        checks++; if ({fault, locked, step_pulse, err_pulse} !== 4'b0) begin errors++; $display("FAIL clr_flags got=%b want=0", {fault, locked, step_pulse, err_pulse}); end
        checks++; if ({step_count, wrap_count, err_count} !== '0) begin errors++; $display("FAIL clr_counts steps=%0d wraps=%0d errs=%0d want 0", step_count, wrap_count, err_count); end
        count_in = 4'd10; tick();
        checks++; if ({step_pulse, locked, period_valid} !== 3'b110) begin errors++; $display("FAIL reacq_first got=%b want=110", {step_pulse, locked, period_valid}); end
        count_in = 4'd11; tick();
        checks++; if ({locked, period_valid} !== 2'b11 || period !== 24'd1) begin errors++; $display("FAIL reacq_second lock/pv=%b period=%0d want 11/1", {locked, period_valid}, period); end
    endtask

    task automatic test_down_step();
        int seen = 0;
        do_reset(4'd6);
        tick(); tick();
        count_in = 4'd7; tick();
        count_in = 4'd6; tick();
        checks++; if ({err_pulse, fault, locked} !== 3'b110) begin errors++; $display("FAIL down_detect got=%b want=110", {err_pulse, fault, locked}); end
        for (int i = 0; i < 100; i++) begin
            tick();
            if (err_pulse) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL down_hold_err pulses=%0d want=0", seen); end
        checks++; if (err_count !== 8'd1 || fault !== 1'b1) begin errors++; $display("FAIL down_hold_state errs=%0d fault=%b want 1/1", err_count, fault); end
    endtask

    task automatic test_stall();
        do_reset(4'd2);
        tick(); tick();
        count_in = 4'd3; tick();
        for (int i = 1; i <= 16; i++) begin
            tick();
            checks++; if (stall !== (i == 16)) begin errors++; $display("FAIL stall_edge%0d got=%b want=%b", i, stall, (i == 16)); end
        end
        count_in = 4'd4; tick();
        checks++; if ({stall, step_pulse, period_valid} !== 3'b011) begin errors++; $display("FAIL stall_clear got=%b want=011", {stall, step_pulse, period_valid}); end
        checks++; if (period !== 24'd17) begin errors++; $display("FAIL stall_period got=%0d want=17", period); end
    endtask

    task automatic test_async_reset();
        do_reset(4'd0);
        tick();
        for (int i = 1; i <= 9; i++) begin
            count_in = 4'(i); tick(); tick();
        end
        checks++; if (step_count !== 16'd9 || locked !== 1'b1) begin errors++; $display("FAIL arst_pre steps=%0d locked=%b want 9/1", step_count, locked); end
        @(negedge clk_in); #1;
        rst = 1'b1; #1;
        checks++; if ({locked, fault, stall, step_pulse, wrap_pulse, err_pulse, period_valid} !== 7'b0 || {period, step_count, wrap_count, err_count} !== '0) begin errors++; $display("FAIL arst_immediate steps=%0d period=%0d locked=%b want 0", step_count, period, locked); end
        tick();
        rst = 1'b0;
        tick(); tick();
        count_in = 4'd10; tick();
        checks++; if ({step_pulse, period_valid, locked} !== 3'b101) begin errors++; $display("FAIL arst_reacq got=%b want=101", {step_pulse, period_valid, locked}); end
    endtask

    task automatic test_clr_on_wrap();
        do_reset(4'd14);
        tick(); tick();
        count_in = 4'd15; tick();
        count_in = 4'd0; clr = 1'b1; tick(); clr = 1'b0;
        checks++; if ({wrap_pulse, step_pulse, locked} !== 3'b0 || wrap_count !== 8'd0) begin errors++; $display("FAIL clrwrap flags=%b wraps=%0d want 0/0", {wrap_pulse, step_pulse, locked}, wrap_count); end
        count_in = 4'd1; tick();
        checks++; if ({step_pulse, wrap_pulse, locked, err_pulse} !== 4'b1010) begin errors++; $display("FAIL clrwrap_next got=%b want=1010", {step_pulse, wrap_pulse, locked, err_pulse}); end
    endtask

    task automatic test_back_to_back();
        do_reset(4'd0);
        tick();
        for (int n = 1; n <= 4160; n++) begin
            count_in = 4'(n); tick();
        end
        checks++; if ({wrap_pulse, step_pulse, period_valid} !== 3'b111 || period !== 24'd1) begin errors++; $display("FAIL b2b_last pulses=%b period=%0d want 111/1", {wrap_pulse, step_pulse, period_valid}, period); end
        checks++; if (wrap_count !== 8'd255 || step_count !== 16'd4160) begin errors++; $display("FAIL b2b_counts wraps=%0d steps=%0d want 255/4160", wrap_count, step_count); end
        do_reset(4'd0);
        tick();
        for (int n = 0; n < 260; n++) begin
            count_in = (n % 2 == 0) ? 4'd2 : 4'd0; tick();
        end
        checks++; if (err_count !== 8'd255 || err_pulse !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL err_saturate errs=%0d pulse=%b locked=%b want 255/1/0", err_count, err_pulse, locked); end
    endtask

    initial begin
        test_reset();
        test_count_seq();
        test_illegal_jump();
        test_down_step();
        test_stall();
        test_async_reset();
        test_clr_on_wrap();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
